// File: rtl/watch_timekeeper_if.sv
// Bundle of the time-of-day inputs and outputs of watch_timekeeper.
// The design side uses the slave modport; the driver/consumer side uses master.
interface watch_timekeeper_if;
    logic       slow_clk;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hour;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       pm;
    logic       sec_pulse;
    logic       day_pulse;

    modport master (
        output slow_clk, set_mode, inc_min, inc_hour,
        input  sec, min, hour, pm, sec_pulse, day_pulse
    );

    modport slave (
        input  slow_clk, set_mode, inc_min, inc_hour,
        output sec, min, hour, pm, sec_pulse, day_pulse
    );
endinterface

// File: rtl/watch_timekeeper.sv
// Synchronises the divided watch clock, prescales its rising edges into seconds and
// keeps hh:mm:ss with a set mode. Define WATCH_12H_EN for a 12-hour display with PM flag.
module watch_timekeeper #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int PRESCALE_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    watch_timekeeper_if.slave bus
);

    localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(TICKS_PER_SEC - 1);

    logic                  sync_a_q, sync_b_q, prev_q;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [5:0]            sec_q, sec_d;
    logic [5:0]            min_q, min_d;
    logic [4:0]            hr24_q, hr24_d;
    logic                  sec_pulse_q, sec_pulse_d;
    logic                  day_pulse_q, day_pulse_d;
    logic                  tick;
    logic                  sec_max, min_max, hr_max;
    logic [4:0]            hour_disp;
    logic                  pm_disp;

    assign tick    = sync_b_q & ~prev_q;
    assign sec_max = (sec_q == 6'd59);
    assign min_max = (min_q == 6'd59);
    assign hr_max  = (hr24_q == 5'd23);

    always_comb begin
        presc_d     = presc_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hr24_d      = hr24_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        if (bus.set_mode) begin
            // Frozen: partial second is discarded, minutes adjust without carry.
            presc_d = '0;
            sec_d   = '0;
            if (bus.inc_min) begin
                min_d = min_max ? 6'd0 : min_q + 6'd1;
            end
            if (bus.inc_hour) begin
                hr24_d = hr_max ? 5'd0 : hr24_q + 5'd1;
            end
        end else if (tick) begin
            if (presc_q == PRESC_MAX) begin
                presc_d     = '0;
                sec_pulse_d = 1'b1;
                if (sec_max) begin
                    sec_d = 6'd0;
                    if (min_max) begin
                        min_d = 6'd0;
                        if (hr_max) begin
                            hr24_d      = 5'd0;
                            day_pulse_d = 1'b1;
                        end else begin
                            hr24_d = hr24_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a_q    <= 1'b0;
            sync_b_q    <= 1'b0;
            prev_q      <= 1'b0;
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hr24_q      <= '0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            sync_a_q    <= bus.slow_clk;
            sync_b_q    <= sync_a_q;
            prev_q      <= sync_b_q;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr24_q      <= hr24_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
        end
    end

`ifdef WATCH_12H_EN
    // Midnight and noon both display as 12; PM covers 12:00-23:59.
    always_comb begin
        if (hr24_q == 5'd0) begin
            hour_disp = 5'd12;
        end else if (hr24_q > 5'd12) begin
            hour_disp = hr24_q - 5'd12;
        end else begin
            hour_disp = hr24_q;
        end
        pm_disp = (hr24_q >= 5'd12);
    end
`else
    always_comb begin
        hour_disp = hr24_q;
        pm_disp   = 1'b0;
    end
`endif

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hour      = hour_disp;
    assign bus.pm        = pm_disp;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.day_pulse = day_pulse_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Bench for watch_timekeeper: two instances (1 and 4 ticks per second) share one stimulus
// stream and are compared every cycle against a seconds-of-day model.
module tb_watch_timekeeper;

    logic clk = 1'b0;
    logic rst_n;
    logic slow_clk, set_mode, inc_min, inc_hour;

    int checks   = 0;
    int failures = 0;

    watch_timekeeper_if if1 ();
    watch_timekeeper_if if4 ();

    assign if1.slow_clk = slow_clk;
    assign if1.set_mode = set_mode;
    assign if1.inc_min  = inc_min;
    assign if1.inc_hour = inc_hour;
    assign if4.slow_clk = slow_clk;
    assign if4.set_mode = set_mode;
    assign if4.inc_min  = inc_min;
    assign if4.inc_hour = inc_hour;

    watch_timekeeper #(.TICKS_PER_SEC(1), .PRESCALE_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );
    watch_timekeeper #(.TICKS_PER_SEC(4), .PRESCALE_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );

    always #5 clk = ~clk;

`ifdef WATCH_12H_EN
    localparam int HOUR_AT_0  = 12;
    localparam int HOUR_AT_23 = 11;
    localparam int PM_AT_12   = 1;
    localparam int PM_AT_23   = 1;
`else
    localparam int HOUR_AT_0  = 0;
    localparam int HOUR_AT_23 = 23;
    localparam int PM_AT_12   = 0;
    localparam int PM_AT_23   = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_hour(input int h);
`ifdef WATCH_12H_EN
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
`else
        return h;
`endif
    endfunction

    function automatic int exp_pm(input int h);
`ifdef WATCH_12H_EN
        return (h >= 12) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Model: time as seconds-of-day; a slow_clk rise seen at edge k becomes a tick at edge k+2.
    int  cyc = 0;
    bit  mvalid = 1'b0;
    bit  last_slow;
    int  pend[$];
    int  mT[2], mP[2];
    bit  msp[2], mdp[2];
    int  tps[2] = '{1, 4};

    always @(posedge clk) begin
        bit tk;
        int h, m;
        cyc++;
        if (!rst_n) begin
            mvalid    = 1'b1;
            last_slow = 1'b0;
            pend.delete();
            for (int i = 0; i < 2; i++) begin
                mT[i] = 0; mP[i] = 0; msp[i] = 1'b0; mdp[i] = 1'b0;
            end
        end else begin
            tk = 1'b0;
            if (pend.size() > 0 && pend[0] == cyc) begin
                tk = 1'b1;
                void'(pend.pop_front());
            end
            if (slow_clk && !last_slow) pend.push_back(cyc + 2);
            last_slow = slow_clk;
            for (int i = 0; i < 2; i++) begin
                msp[i] = 1'b0;
                mdp[i] = 1'b0;
                if (set_mode) begin
                    mP[i] = 0;
                    h = mT[i] / 3600;
                    m = (mT[i] / 60) % 60;
                    if (inc_min)  m = (m + 1) % 60;
                    if (inc_hour) h = (h + 1) % 24;
                    mT[i] = h * 3600 + m * 60;
                end else if (tk) begin
                    mP[i]++;
                    if (mP[i] == tps[i]) begin
                        mP[i] = 0;
                        mT[i] = (mT[i] + 1) % 86400;
                        msp[i] = 1'b1;
                        mdp[i] = (mT[i] == 0);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("d1.sec",       int'(if1.sec),       mT[0] % 60);
            chk("d1.min",       int'(if1.min),       (mT[0] / 60) % 60);
            chk("d1.hour",      int'(if1.hour),      exp_hour(mT[0] / 3600));
            chk("d1.pm",        int'(if1.pm),        exp_pm(mT[0] / 3600));
            chk("d1.sec_pulse", int'(if1.sec_pulse), int'(msp[0]));
            chk("d1.day_pulse", int'(if1.day_pulse), int'(mdp[0]));
            chk("d4.sec",       int'(if4.sec),       mT[1] % 60);
            chk("d4.min",       int'(if4.min),       (mT[1] / 60) % 60);
            chk("d4.hour",      int'(if4.hour),      exp_hour(mT[1] / 3600));
            chk("d4.pm",        int'(if4.pm),        exp_pm(mT[1] / 3600));
            chk("d4.sec_pulse", int'(if4.sec_pulse), int'(msp[1]));
            chk("d4.day_pulse", int'(if4.day_pulse), int'(mdp[1]));
        end
    end

    bit cnt_en = 1'b0;
    int pcount = 0;
    always @(negedge clk) begin
        if (cnt_en && if4.sec_pulse) pcount++;
    end

    task automatic tick();
        @(negedge clk) slow_clk = 1'b1;
        repeat (2) @(negedge clk);
        slow_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_min();
        @(negedge clk) inc_min = 1'b1;
        @(negedge clk) inc_min = 1'b0;
    endtask

    task automatic pulse_hour();
        @(negedge clk) inc_hour = 1'b1;
        @(negedge clk) inc_hour = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        slow_clk = 1'b0;
        set_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; slow_clk = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        // Reset with slow_clk toggling.
        @(negedge clk) slow_clk = 1'b1;
        @(negedge clk) slow_clk = 1'b0;
        @(negedge clk) slow_clk = 1'b1;
        @(negedge clk) begin slow_clk = 1'b0; rst_n = 1'b1; end
        @(negedge clk);
        chk("rst.sec",  int'(if1.sec), 0);
        chk("rst.min",  int'(if1.min), 0);
        chk("rst.hour", int'(if1.hour), HOUR_AT_0);
        chk("rst.pm",   int'(if1.pm), 0);
        chk("rst.sp",   int'(if1.sec_pulse), 0);
        chk("rst.dp",   int'(if4.day_pulse), 0);
        repeat (3) tick();
        chk("pre3.d4.sec", int'(if4.sec), 0);
        chk("pre3.d1.sec", int'(if1.sec), 3);
        tick();
        chk("pre4.d4.sec", int'(if4.sec), 1);

        // Latency on the 1-tick instance, then a long high level.
        do_reset();
        @(negedge clk) slow_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lat.n1.sec", int'(if1.sec), 0);
        chk("lat.n1.sp",  int'(if1.sec_pulse), 0);
        @(negedge clk);
        chk("lat.n2.sec", int'(if1.sec), 1);
        chk("lat.n2.sp",  int'(if1.sec_pulse), 1);
        @(negedge clk);
        chk("lat.n3.sp",  int'(if1.sec_pulse), 0);
        repeat (46) @(negedge clk);
        chk("hold.sec", int'(if1.sec), 1);
        slow_clk = 1'b0;
        repeat (3) @(negedge clk);

        // Prescale and minute carry.
        do_reset();
        pcount = 0;
        cnt_en = 1'b1;
        repeat (240) tick();
        repeat (2) @(negedge clk);
        cnt_en = 1'b0;
        chk("ps.d4.sec", int'(if4.sec), 0);
        chk("ps.d4.min", int'(if4.min), 1);
        chk("ps.pulses", pcount, 60);
        chk("ps.d1.min", int'(if1.min), 4);

        // Day rollover.
        do_reset();
        @(negedge clk) set_mode = 1'b1;
        repeat (23) pulse_hour();
        repeat (59) pulse_min();
        @(negedge clk) set_mode = 1'b0;
        chk("day.h23",  int'(if1.hour), HOUR_AT_23);
        chk("day.pm23", int'(if1.pm), PM_AT_23);
        repeat (59) tick();
        chk("day.sec59", int'(if1.sec), 59);
        chk("day.min59", int'(if1.min), 59);
        @(negedge clk) slow_clk = 1'b1;
        repeat (3) @(negedge clk);
        chk("day.sp",   int'(if1.sec_pulse), 1);
        chk("day.dp",   int'(if1.day_pulse), 1);
        chk("day.sec",  int'(if1.sec), 0);
        chk("day.min",  int'(if1.min), 0);
        chk("day.hour", int'(if1.hour), HOUR_AT_0);
        chk("day.pm",   int'(if1.pm), 0);
        slow_clk = 1'b0;
        @(negedge clk);
        chk("day.dp_off", int'(if1.day_pulse), 0);

        // Noon display.
        @(negedge clk) set_mode = 1'b1;
        repeat (12) pulse_hour();
        chk("noon.hour", int'(if1.hour), 12);
        chk("noon.pm",   int'(if1.pm), PM_AT_12);

        // Set mode behaviour.
        do_reset();
        repeat (37) tick();
        chk("set.sec37", int'(if1.sec), 37);
        @(negedge clk) set_mode = 1'b1;
        @(negedge clk);
        chk("set.sec0", int'(if1.sec), 0);
        repeat (59) pulse_min();
        chk("set.min59", int'(if1.min), 59);
        pulse_min();
        chk("set.minwrap", int'(if1.min), 0);
        chk("set.nocarry", int'(if1.hour), HOUR_AT_0);
        repeat (5) pulse_hour();
        repeat (10) pulse_min();
        @(negedge clk) begin inc_min = 1'b1; inc_hour = 1'b1; end
        @(negedge clk) begin inc_min = 1'b0; inc_hour = 1'b0; end
        chk("set.both.min",  int'(if1.min), 11);
        chk("set.both.hour", int'(if1.hour), 6);
        repeat (3) tick();
        chk("set.frozen.sec", int'(if1.sec), 0);
        chk("set.frozen.min", int'(if1.min), 11);
        set_mode = 1'b0;
        pulse_min();
        pulse_hour();
        chk("run.ign.min",  int'(if1.min), 11);
        chk("run.ign.hour", int'(if1.hour), 6);
        tick();
        chk("run.resume.d1", int'(if1.sec), 1);
        chk("run.resume.d4", int'(if4.sec), 0);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/watch_timekeeper.md
Name: watch_timekeeper

Overview:
- Fast-clock-domain consumer of the divided clock produced by the watch clock divider.
- Synchronises the divided clock, detects its rising edges and prescales them into 1 Hz seconds.
- Maintains the hours:minutes:seconds time-of-day registers, with a set mode for manual adjustment.
- Output feeds the display/BCD formatting stage.

Parameters:
TICKS_PER_SEC, 1000, number of divided-clock rising edges per second; legal range 1 to 65535
PRESCALE_W, 16, width of the internal edge prescaler; must satisfy 2^PRESCALE_W > TICKS_PER_SEC

Ports:
clk  input  1  system clock; same clock that drives the divider
rst_n  input  1  synchronous active-low reset
slow_clk  input  1  divided clock from the divider; treated as asynchronous
set_mode  input  1  level; 1 = time frozen and adjustable
inc_min  input  1  single-cycle pulse, synchronous to clk; minute +1 while set_mode=1
inc_hour  input  1  single-cycle pulse, synchronous to clk; hour +1 while set_mode=1
sec  output  6  seconds, binary 0-59
min  output  6  minutes, binary 0-59
hour  output  5  hours, binary; range depends on WATCH_12H_EN
pm  output  1  PM flag; function depends on WATCH_12H_EN
sec_pulse  output  1  one-cycle strobe on every seconds increment
day_pulse  output  1  one-cycle strobe on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- All state changes occur on the rising edge of clk. Reset is synchronous: rst_n=0 sampled at an edge forces all of the following at that edge:
  - sync_a, sync_b, prev = 0
  - prescaler = 0
  - sec, min = 0; internal 24-hour counter hr24 = 0
  - sec_pulse, day_pulse = 0
  - reset dominates every other input
- Synchroniser:
  - Two flops: slow_clk -> sync_a -> sync_b. A third flop, prev, holds the previous sync_b.
  - tick = sync_b & ~prev (combinational).
  - Latency: a slow_clk rise sampled at edge N gives tick=1 during the cycle after edge N+1. Any register update from that tick lands at edge N+2.
  - Exactly one tick per slow_clk rising edge; slow_clk falling edges are ignored.
- Run mode (set_mode=0), on tick:
  - If prescaler == TICKS_PER_SEC-1: prescaler <= 0 and the seconds increment.
  - Otherwise: prescaler <= prescaler+1.
- Seconds increment:
  - sec+1. At 59, sec wraps to 0 and min increments.
  - min at 59 wraps to 0 and hr24 increments.
  - hr24 at 23 wraps to 0.
  - All carries resolve in the same clock edge.
- Strobes:
  - sec_pulse is registered, high for exactly the one cycle after each seconds-increment edge.
  - day_pulse is high in that same cycle only when the increment wrapped 23:59:59 -> 00:00:00.
- Set mode (set_mode=1):
  - prescaler and sec are held at 0. Ticks are discarded. sec_pulse and day_pulse = 0.
  - inc_min: min+1, wrap 59->0, no carry into hour.
  - inc_hour: hr24+1, wrap 23->0.
  - Both pulses in the same cycle: both fields update independently in that edge.
  - inc_min and inc_hour are ignored when set_mode=0.
- Exit from set mode: counting resumes from sec=0, prescaler=0. The first seconds increment occurs on the TICKS_PER_SEC-th tick after exit.
- Entry into set mode mid-second discards the accumulated prescale.
- Reset mid-operation: output values at the reset edge are discarded; time restarts at 00:00:00.

Optional Feature:
- Macro: WATCH_12H_EN.
- Defined:
  - hour presents 12-hour format: hr24=0 -> 12, 1-12 -> unchanged, 13-23 -> hr24-12.
  - pm = (hr24 >= 12).
  - The conversion is combinational from hr24; no added latency.
- Undefined:
  - hour = hr24 (0-23).
  - pm tied to 0.
- Internal counting and wrap rules are identical in both builds.

Test Plan:
- Reset: rst_n=0 for 2 cycles with slow_clk toggling -> sec=min=hour=0, pm=0, both strobes 0; first increment occurs only after TICKS_PER_SEC ticks following reset release.
- Latency (TICKS_PER_SEC=1): slow_clk rises just before edge N -> sec changes 0->1 at edge N+2; sec_pulse high for exactly the following cycle; slow_clk held high for 50 cycles yields exactly one increment.
- Prescale and carry (TICKS_PER_SEC=4): 240 slow_clk rising edges -> sec=0, min=1; exactly 60 sec_pulse strobes observed.
- Day rollover (TICKS_PER_SEC=1): set hr24=23, min=59 via set mode, exit, run 59 ticks -> 23:59:59; next tick -> 00:00:00 with sec_pulse=1 and day_pulse=1 in the same cycle.
- Set mode: set_mode=1 at sec=37 -> sec=0 next edge; inc_min at min=59 -> min=0 with hour unchanged; inc_hour and inc_min in the same cycle from 05:10 -> 06:11; slow_clk ticks during set mode cause no change; inc pulses with set_mode=0 are ignored.
- WATCH_12H_EN defined: hr24=0 -> hour=12, pm=0; hr24=12 -> hour=12, pm=1; hr24=23 -> hour=11, pm=1. Undefined: hr24=23 -> hour=23, pm=0.
